// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: reassembles two-byte inverter commands from uart_rx into a
// 12-bit sine index and 4-bit id, and flags id match, byte errors, inter-byte
// timeouts and loss of link.
module uart_frame_decoder #(
   parameter logic [3:0]  MODULE_ID    = 4'd1,
   parameter int unsigned BYTE_TIMEOUT = 1200,
   parameter int unsigned LINK_TIMEOUT = 240000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data_received,
   input  logic        rx_done,
   input  logic        parity_error,
   output logic [11:0] sin_index,
   output logic [3:0]  uart_id,
   output logic        frame_valid,
   output logic        id_match,
   output logic        frame_err,
   output logic [7:0]  err_count,
   output logic        link_ok
);

   localparam int unsigned GAP_W  = $clog2(BYTE_TIMEOUT) + 1;
   localparam int unsigned LINK_W = $clog2(LINK_TIMEOUT) + 1;
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
   localparam logic [LINK_W-1:0] LINK_MAX = LINK_W'(LINK_TIMEOUT);

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        hi_byte_q, hi_byte_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [LINK_W-1:0] link_cnt_q, link_cnt_d;
   logic [11:0]       sin_index_q, sin_index_d;
   logic [3:0]        uart_id_q, uart_id_d;
   logic              id_match_q, id_match_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        err_count_q, err_count_d;
   logic              link_ok_q, link_ok_d;

   // Frame FSM: byte pairing, gap timeout, and capture of good frames.
   always_comb begin
      state_d       = state_q;
      hi_byte_d     = hi_byte_q;
      gap_cnt_d     = gap_cnt_q;
      sin_index_d   = sin_index_q;
      uart_id_d     = uart_id_q;
      id_match_d    = id_match_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      case (state_q)
         WAIT_HI: begin
            gap_cnt_d = '0;
            if (rx_done) begin
               if (parity_error) begin
                  frame_err_d = 1'b1;
               end else begin
                  hi_byte_d = data_received;
                  state_d   = WAIT_LO;
               end
            end
         end
         WAIT_LO: begin
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (rx_done) begin
               state_d   = WAIT_HI;
               gap_cnt_d = '0;
               if (parity_error) begin
                  frame_err_d = 1'b1;
               end else begin
                  sin_index_d   = {hi_byte_q, data_received[7:4]};
                  uart_id_d     = data_received[3:0];
                  id_match_d    = (data_received[3:0] == MODULE_ID) ||
                                  (data_received[3:0] == 4'hF);
                  frame_valid_d = 1'b1;
               end
            end else if (gap_cnt_q == GAP_LAST) begin
               frame_err_d = 1'b1;
               state_d     = WAIT_HI;
               gap_cnt_d   = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_HI;
      endcase
   end

   // Saturating error counter and link watchdog.
   always_comb begin
      err_count_d = err_count_q;
      link_cnt_d  = link_cnt_q;
      link_ok_d   = link_ok_q;
      if (frame_err_d && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
      if (frame_valid_d) begin
         link_cnt_d = '0;
         link_ok_d  = 1'b1;
      end else begin
         if (link_cnt_q != LINK_MAX) begin
            link_cnt_d = link_cnt_q + 1'b1;
         end
         if (link_cnt_d == LINK_MAX) begin
            link_ok_d = 1'b0;
         end
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= WAIT_HI;
         hi_byte_q     <= '0;
         gap_cnt_q     <= '0;
         link_cnt_q    <= '0;
         sin_index_q   <= '0;
         uart_id_q     <= '0;
         id_match_q    <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         err_count_q   <= '0;
         link_ok_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hi_byte_q     <= hi_byte_d;
         gap_cnt_q     <= gap_cnt_d;
         link_cnt_q    <= link_cnt_d;
         sin_index_q   <= sin_index_d;
         uart_id_q     <= uart_id_d;
         id_match_q    <= id_match_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         err_count_q   <= err_count_d;
         link_ok_q     <= link_ok_d;
      end
   end

   assign sin_index   = sin_index_q;
   assign uart_id     = uart_id_q;
   assign id_match    = id_match_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign err_count   = err_count_q;
   assign link_ok     = link_ok_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: table of two-byte frames plus hand-written
// sequences for timeout, link loss, error saturation and mid-frame reset.
module tb_uart_frame_decoder;

   logic        clk;
   logic        reset;
   logic [7:0]  data_received;
   logic        rx_done;
   logic        parity_error;
   logic [11:0] sin_index;
   logic [3:0]  uart_id;
   logic        frame_valid;
   logic        id_match;
   logic        frame_err;
   logic [7:0]  err_count;
   logic        link_ok;

   uart_frame_decoder #(
      .MODULE_ID(4'd1),
      .BYTE_TIMEOUT(16),
      .LINK_TIMEOUT(100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .data_received(data_received),
      .rx_done(rx_done),
      .parity_error(parity_error),
      .sin_index(sin_index),
      .uart_id(uart_id),
      .frame_valid(frame_valid),
      .id_match(id_match),
      .frame_err(frame_err),
      .err_count(err_count),
      .link_ok(link_ok)
   );

   typedef struct {
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic        perr;
      logic [11:0] sin;
      logic [3:0]  id;
      logic        m;
   } vec_t;

   typedef struct {
      logic [11:0] sin;
      logic [3:0]  id;
      logic        m;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   err_pulses = 0;
   int   exp_err    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; presents one byte for exactly one rising edge.
   task automatic send(input logic [7:0] b, input logic pe);
      data_received = b;
      parity_error  = pe;
      rx_done       = 1'b1;
      @(negedge clk);
      rx_done       = 1'b0;
      parity_error  = 1'b0;
      data_received = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [11:0] s, input logic [3:0] i, input logic m);
      exp_t e;
      e.sin = s; e.id = i; e.m = m;
      sb.push_back(e);
   endtask

   function automatic int sat_err(input int e);
      return (e > 255) ? 255 : e;
   endfunction

   task automatic check_state(input string tag, input logic [11:0] s, input logic [3:0] i,
                              input logic m, input logic lk);
      chk({tag, "_sin"}, 32'(sin_index), 32'(s));
      chk({tag, "_id"}, 32'(uart_id), 32'(i));
      chk({tag, "_match"}, 32'(id_match), 32'(m));
      chk({tag, "_errcnt"}, 32'(err_count), 32'(sat_err(exp_err)));
      chk({tag, "_errpulses"}, 32'(err_pulses), 32'(exp_err));
      chk({tag, "_link"}, 32'(link_ok), 32'(lk));
   endtask

   // Scoreboard side: pop one expectation per frame_valid pulse, tally frame_err pulses.
   always @(negedge clk) begin
      if (frame_err) err_pulses++;
      if (frame_valid) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_frame", 32'(frame_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_sin", 32'(sin_index), 32'(e.sin));
            chk("sb_id", 32'(uart_id), 32'(e.id));
            chk("sb_match", 32'(id_match), 32'(e.m));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'hAB, 8'hC1, 1'b0, 12'hABC, 4'h1, 1'b1};
      vecs[1] = '{8'h12, 8'h35, 1'b0, 12'h123, 4'h5, 1'b0};
      vecs[2] = '{8'h12, 8'h3F, 1'b0, 12'h123, 4'hF, 1'b1};
      vecs[3] = '{8'h55, 8'h66, 1'b1, 12'h123, 4'hF, 1'b1};
      vecs[4] = '{8'h01, 8'h21, 1'b0, 12'h012, 4'h1, 1'b1};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 12'h000, 4'h0, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b0, 12'hFFF, 4'hF, 1'b1};
      vecs[7] = '{8'hA5, 8'hE2, 1'b0, 12'hA5E, 4'h2, 1'b0};

      reset = 1'b0; rx_done = 1'b0; parity_error = 1'b0; data_received = 8'h00;
      idle(3);
      chk("rst_fv", 32'(frame_valid), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      check_state("rst", 12'h000, 4'h0, 1'b0, 1'b0);
      reset = 1'b1;
      idle(2);

      // Table: high byte then low byte back-to-back.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].hi, 1'b0);
         if (!vecs[i].perr) push_exp(vecs[i].sin, vecs[i].id, vecs[i].m);
         else exp_err++;
         send(vecs[i].lo, vecs[i].perr);
         chk("fv_latency", 32'(frame_valid), 32'(!vecs[i].perr));
         chk("ferr_latency", 32'(frame_err), 32'(vecs[i].perr));
         idle(2);
         check_state($sformatf("vec%0d", i), vecs[i].sin, vecs[i].id, vecs[i].m, 1'b1);
      end

      // Parity error on a high byte: dropped, next byte starts the frame.
      send(8'h99, 1'b1);
      exp_err++;
      send(8'h45, 1'b0);
      push_exp(12'h456, 4'h1, 1'b1);
      send(8'h61, 1'b0);
      idle(2);
      check_state("hi_perr", 12'h456, 4'h1, 1'b1, 1'b1);

      // Low byte on the exact timeout cycle is still accepted.
      send(8'h31, 1'b0);
      idle(15);
      push_exp(12'h314, 4'h1, 1'b1);
      send(8'h41, 1'b0);
      idle(2);
      check_state("to_edge_ok", 12'h314, 4'h1, 1'b1, 1'b1);

      // One cycle later the timeout fires; following bytes resync.
      send(8'h77, 1'b0);
      idle(16);
      exp_err++;
      send(8'h88, 1'b0);
      push_exp(12'h889, 4'h1, 1'b1);
      send(8'h91, 1'b0);
      idle(2);
      check_state("to_edge_err", 12'h889, 4'h1, 1'b1, 1'b1);

      // Long gap timeout then good frame.
      send(8'h77, 1'b0);
      idle(20);
      exp_err++;
      chk("to_long_errpulses", 32'(err_pulses), 32'(exp_err));
      push_exp(12'h889, 4'h1, 1'b1);
      send(8'h88, 1'b0);
      send(8'h91, 1'b0);
      // Link loss: still up shortly before the watchdog limit, down after it.
      idle(90);
      chk("link_before_to", 32'(link_ok), 32'd1);
      idle(15);
      check_state("link_lost", 12'h889, 4'h1, 1'b1, 1'b0);

      // Error counter saturation.
      for (int i = 0; i < 300; i++) begin
         send(8'($urandom_range(0, 255)), 1'b1);
         exp_err++;
      end
      idle(2);
      check_state("sat", 12'h889, 4'h1, 1'b1, 1'b0);

      // Asynchronous reset in WAIT_LO.
      send(8'h5A, 1'b0);
      idle(2);
      #3 reset = 1'b0;
      #1;
      chk("arst_fv", 32'(frame_valid), 32'd0);
      chk("arst_ferr", 32'(frame_err), 32'd0);
      exp_err = 0;
      err_pulses = 0;
      check_state("arst", 12'h000, 4'h0, 1'b0, 1'b0);
      idle(3);
      chk("arst_noerr", 32'(err_pulses), 32'd0);
      reset = 1'b1;
      idle(1);
      push_exp(12'hABC, 4'h1, 1'b1);
      send(8'hAB, 1'b0);
      send(8'hC1, 1'b0);
      idle(2);
      check_state("post_rst", 12'hABC, 4'h1, 1'b1, 1'b1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Module-side receive stage for the inverter command link. Consumes the byte stream from one `uart_rx` instance. Each command is two bytes: `sin_index[11:4]`, then `{sin_index[3:0], uart_id}`. The block reassembles the pair into a 12-bit sine index and a 4-bit id, then flags id match, framing/parity errors and link loss. It sits directly downstream of the main FPGA's UART transmitters, on each module board, in the `clk_24` domain.

## Interface
- `MODULE_ID`, 4'd1: id of this module; frames with `uart_id == MODULE_ID` or `4'hF` (broadcast) set `id_match`.
- `BYTE_TIMEOUT`, 1200: max cycles allowed between the high-byte and low-byte `rx_done`.
- `LINK_TIMEOUT`, 240000: cycles without a good frame before `link_ok` drops (10 ms at 24 MHz).

Ports:
- `clk`  in  1  system clock (`clk_24`).
- `reset`  in  1  asynchronous, active-low reset.
- `data_received`  in  8  byte from `uart_rx`; valid only while `rx_done` = 1.
- `rx_done`  in  1  one-cycle byte strobe.
- `parity_error`  in  1  qualifies the current `rx_done` byte.
- `sin_index`  out  12  last good sine index.
- `uart_id`  out  4  last good id.
- `frame_valid`  out  1  one-cycle pulse per good frame.
- `id_match`  out  1  registered with `sin_index`; id equals `MODULE_ID` or `4'hF`.
- `frame_err`  out  1  one-cycle pulse on a parity error or inter-byte timeout.
- `err_count`  out  8  saturating error counter.
- `link_ok`  out  1  1 while good frames keep arriving within `LINK_TIMEOUT`.

## Operation
- FSM states:
  - `WAIT_HI`: reset state.
  - `WAIT_LO`: high byte held in `hi_byte`; gap counter `gap_cnt` running.
- `WAIT_HI`, `rx_done` and !`parity_error`: store byte into `hi_byte`, clear `gap_cnt`, go to `WAIT_LO`.
- `WAIT_HI`, `rx_done` and `parity_error`: drop the byte, pulse `frame_err`, stay.
- `WAIT_LO`, `rx_done` and !`parity_error`: frame is good.
  - `sin_index <= {hi_byte, data_received[7:4]}`, `uart_id <= data_received[3:0]`, `id_match` updated.
  - Pulse `frame_valid`; go to `WAIT_HI`.
- `WAIT_LO`, `rx_done` and `parity_error`: discard the frame, pulse `frame_err`, go to `WAIT_HI`. The byte is not reused as a high byte.
- `WAIT_LO`, no `rx_done`: `gap_cnt` increments.
  - When `gap_cnt == BYTE_TIMEOUT-1`: pulse `frame_err`, go to `WAIT_HI` (resync).
- `rx_done` in the same cycle as the timeout: the byte wins and is treated as the low byte.
- `err_count` increments on every `frame_err` and saturates at 255. It is cleared only by reset.
- Link watchdog `link_cnt`:
  - Cleared on `frame_valid`, otherwise increments, saturating at `LINK_TIMEOUT`.
  - `link_ok` <= 1 on `frame_valid`; `link_ok` <= 0 when `link_cnt` reaches `LINK_TIMEOUT`.
- Outputs hold their last good values between frames; bad frames never alter `sin_index`, `uart_id` or `id_match`.
- Counter widths are `$clog2` of the respective parameter plus 1. There is no wrap-around.

## Timing
- Reset (`reset` = 0, async): state `WAIT_HI`; every output 0, including `link_ok`; `hi_byte`, `gap_cnt` and `link_cnt` all 0.
- `frame_valid`, `sin_index`, `uart_id` and `id_match` all update on the clock edge after the low-byte `rx_done`, giving 1-cycle latency.
- `frame_err` is asserted 1 cycle after either:
  - the offending `rx_done`, or
  - the cycle in which the timeout condition is met.
- Reset during `WAIT_LO` aborts the frame silently: no `frame_err`, `err_count` is 0.
- Back-to-back `rx_done` pulses on consecutive cycles are accepted with no dead cycle.

## Test plan
- Good frame, `MODULE_ID`=1: bytes 0xAB then 0xC1 -> one `frame_valid` pulse, `sin_index`=0xABC, `uart_id`=1, `id_match`=1, `link_ok`=1, `err_count`=0.
- Id filtering: frames 0x12/0x35, then 0x12/0x3F -> `sin_index`=0x123 both times; `id_match`=0, then 1 (broadcast).
- Parity error on the low byte: 0x55, then 0x66 with `parity_error` -> no `frame_valid`, one `frame_err`, `err_count`=1, outputs unchanged; the next 0x01/0x21 decodes to 0x012.
- Timeout resync with `BYTE_TIMEOUT`=16: 0x77, 20 idle cycles, then 0x88/0x91 -> `frame_err` pulse, then `sin_index`=0x889, `uart_id`=1.
- Link loss and saturation with `LINK_TIMEOUT`=100:
  - good frame, then 100 idle cycles -> `link_ok` drops to 0.
  - 300 parity-error bytes -> `err_count`=255.
- Async reset mid-frame: reset pulse during `WAIT_LO` -> all outputs 0 immediately; a following good frame decodes normally.
